// File: rtl/radix_8_ntt64_ctrl_if.sv
// Control bus of the radix-8 NTT-64 sequencer: start/status,
// bank read issue and delayed write-back addressing.
interface radix_8_ntt64_ctrl_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [23:0] rd_row;
    logic [2:0]  rd_rot;
    logic [3:0]  tf_addr;
    logic        wr_en;
    logic [23:0] wr_row;
    logic [2:0]  wr_rot;

    modport master (
        input  start,
        output busy, done,
        output rd_en, rd_row, rd_rot, tf_addr,
        output wr_en, wr_row, wr_rot
    );

    modport slave (
        output start,
        input  busy, done,
        input  rd_en, rd_row, rd_rot, tf_addr,
        input  wr_en, wr_row, wr_rot
    );
endinterface

// File: rtl/radix_8_ntt64_ctrl.sv
// Sequencer for a 64-point 2-stage radix-8 DIT NTT over 8 RAM banks.
// Issues per-butterfly bank rows, crossbar rotation and twiddle address.
module radix_8_ntt64_ctrl #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    radix_8_ntt64_ctrl_if.master bus
);
    localparam int D  = RD_LAT + BF_LAT;
    localparam int CW = ($clog2(D + 1) > 3) ? $clog2(D + 1) : 3;

    typedef enum logic [2:0] {
        IDLE, STAGE0, DRAIN, STAGE1, FLUSH, DONE
    } state_t;

    typedef struct packed {
        logic        en;
        logic [23:0] row;
        logic [2:0]  rot;
    } wb_t;

    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic        r_busy, r_done, r_rd_en;
    logic [23:0] r_rd_row;
    logic [2:0]  r_rd_rot;
    logic [3:0]  r_tf_addr;
    wb_t         r_wb [D];

    logic        w_busy, w_done, w_rd_en;
    logic [23:0] w_rd_row;
    logic [2:0]  w_rd_rot, w_b;
    logic [3:0]  w_tf_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: if (bus.start) begin
                w_state_nxt = STAGE0;
                w_cnt_nxt   = '0;
            end
            STAGE0: if (r_cnt == CW'(7)) begin
                w_state_nxt = DRAIN;
                w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 1'b1;
            DRAIN: if (r_cnt == CW'(D - 1)) begin
                w_state_nxt = STAGE1;
                w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 1'b1;
            STAGE1: if (r_cnt == CW'(7)) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 1'b1;
            FLUSH: if (r_cnt == CW'(D - 1)) begin
                w_state_nxt = DONE;
                w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 1'b1;
            DONE: begin
                w_state_nxt = bus.start ? STAGE0 : IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with it
    always_comb begin
        w_b       = w_cnt_nxt[2:0];
        w_rd_en   = 1'b0;
        w_rd_row  = '0;
        w_rd_rot  = '0;
        w_tf_addr = '0;
        w_busy    = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done    = (w_state_nxt == DONE);
        if (w_state_nxt == STAGE0) begin
            w_rd_en   = 1'b1;
            for (int j = 0; j < 8; j++)
                w_rd_row[3*j +: 3] = 3'(j) - w_b;
            w_rd_rot  = w_b;
            w_tf_addr = {1'b0, w_b};
        end else if (w_state_nxt == STAGE1) begin
            w_rd_en   = 1'b1;
            w_rd_row  = {8{w_b}};
            w_rd_rot  = w_b;
            w_tf_addr = {1'b1, w_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_row  <= '0;
            r_rd_rot  <= '0;
            r_tf_addr <= '0;
            for (int i = 0; i < D; i++) r_wb[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_rd_en   <= w_rd_en;
            r_rd_row  <= w_rd_row;
            r_rd_rot  <= w_rd_rot;
            r_tf_addr <= w_tf_addr;
            r_wb[0]   <= {r_rd_en, r_rd_row, r_rd_rot};
            for (int i = 1; i < D; i++) r_wb[i] <= r_wb[i-1];
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rd_en   = r_rd_en;
    assign bus.rd_row  = r_rd_row;
    assign bus.rd_rot  = r_rd_rot;
    assign bus.tf_addr = r_tf_addr;
    assign bus.wr_en   = r_wb[D-1].en;
    assign bus.wr_row  = r_wb[D-1].row;
    assign bus.wr_rot  = r_wb[D-1].rot;
endmodule

// File: tb/tb_radix_8_ntt64_ctrl.sv
// Directed bench for radix_8_ntt64_ctrl with D=1 and D=5 instances.
// Expected values come from the addressing formulas and cycle tables.
module tb_radix_8_ntt64_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    radix_8_ntt64_ctrl_if b1 ();
    radix_8_ntt64_ctrl_if b5 ();

    radix_8_ntt64_ctrl u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.master)
    );

    radix_8_ntt64_ctrl #(.RD_LAT(2), .BF_LAT(3)) u5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b5.master)
    );

    int errors = 0;
    int checks = 0;
    bit seen0 [64];
    bit seen1 [64];

    task automatic chk(input string tag, input int c,
                       input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {rd_en, rd_row, rd_rot, tf_addr} for cycle c after the start edge
    function automatic logic [31:0] ref_rd(input int c, input int d);
        logic [2:0]  b;
        logic [23:0] row;
        if (c >= 1 && c <= 8) begin
            b = 3'(c - 1);
            for (int j = 0; j < 8; j++) row[3*j +: 3] = 3'(j) - b;
            return {1'b1, row, b, 1'b0, b};
        end
        if (c >= 9 + d && c <= 16 + d) begin
            b = 3'(c - 9 - d);
            return {1'b1, {8{b}}, b, 1'b1, b};
        end
        return 32'h0;
    endfunction

    function automatic logic [27:0] ref_wr(input int c, input int d);
        logic [31:0] r;
        r = ref_rd(c - d, d);
        return r[31:4];
    endfunction

    function automatic logic [1:0] ref_st(input int c, input int d);
        return {(c >= 1 && c <= 16 + 2*d), (c == 17 + 2*d)};
    endfunction

    function automatic logic [63:0] all1();
        return 64'({b1.busy, b1.done, b1.rd_en, b1.rd_row, b1.rd_rot,
                    b1.tf_addr, b1.wr_en, b1.wr_row, b1.wr_rot});
    endfunction

    function automatic logic [63:0] all5();
        return 64'({b5.busy, b5.done, b5.rd_en, b5.rd_row, b5.rd_rot,
                    b5.tf_addr, b5.wr_en, b5.wr_row, b5.wr_rot});
    endfunction

    task automatic check1(input int c, input int cref);
        chk("rd1", c, 64'({b1.rd_en, b1.rd_row, b1.rd_rot, b1.tf_addr}),
            64'(ref_rd(cref, 1)));
        chk("wr1", c, 64'({b1.wr_en, b1.wr_row, b1.wr_rot}),
            64'(ref_wr(cref, 1)));
        chk("st1", c, 64'({b1.busy, b1.done}), 64'(ref_st(cref, 1)));
    endtask

    task automatic check5(input int c);
        chk("rd5", c, 64'({b5.rd_en, b5.rd_row, b5.rd_rot, b5.tf_addr}),
            64'(ref_rd(c, 5)));
        chk("wr5", c, 64'({b5.wr_en, b5.wr_row, b5.wr_rot}),
            64'(ref_wr(c, 5)));
        chk("st5", c, 64'({b5.busy, b5.done}), 64'(ref_st(c, 5)));
    endtask

    // Map each lane back to a coefficient index through the bank layout
    task automatic lanes(input int c, input int cref);
        bit ok;
        int b, st, j, r, i, e;
        if ((cref >= 1 && cref <= 8) || (cref >= 10 && cref <= 17)) begin
            st = (cref >= 10) ? 1 : 0;
            b  = st ? cref - 10 : cref - 1;
            ok = 1'b1;
            for (int k = 0; k < 8; k++) begin
                j = (k + int'(b1.rd_rot)) % 8;
                r = int'(b1.rd_row[3*j +: 3]);
                i = 8*r + ((j - r + 8) % 8);
                e = st ? 8*b + k : b + 8*k;
                if (i != e) ok = 1'b0;
                if (st == 1) seen1[j*8 + r] = 1'b1;
                else seen0[j*8 + r] = 1'b1;
            end
            chk("lane", c, 64'(ok), 64'd1);
        end
    endtask

    task automatic run(input int ncyc, input int pa, input int pb,
                       input bit hold, input bit with5);
        int cref;
        b1.start = 1'b1;
        b5.start = with5;
        step();
        b1.start = 1'b0;
        b5.start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            cref = hold ? ((c - 1) % 19) + 1 : c;
            check1(c, cref);
            lanes(c, cref);
            if (with5) check5(c);
            if (with5 && c == 4)
                chk("row_s0b3", c,
                    64'({b1.rd_row, b1.rd_rot, b1.tf_addr}),
                    64'({24'o43210765, 3'd3, 4'd3}));
            if (with5 && c == 5)
                chk("wrow_s0b3", c, 64'({b1.wr_row, b1.wr_rot}),
                    64'({24'o43210765, 3'd3}));
            if (with5 && c == 13)
                chk("row_s1b3", c,
                    64'({b1.rd_row, b1.rd_rot, b1.tf_addr}),
                    64'({24'o33333333, 3'd3, 4'd11}));
            if (with5 && c == 14)
                chk("wrow_s1b3", c, 64'({b1.wr_row, b1.wr_rot}),
                    64'({24'o33333333, 3'd3}));
            b1.start = hold || (c == pa) || (c == pb);
            step();
        end
        b1.start = 1'b0;
    endtask

    initial begin
        int miss0, miss1;
        rst_n    = 1'b0;
        b1.start = 1'b0;
        b5.start = 1'b0;
        repeat (3) step();
        chk("reset1", 0, all1(), 64'h0);
        chk("reset5", 0, all5(), 64'h0);
        rst_n = 1'b1;
        step();

        // Full transform on both instances, plus coverage
        foreach (seen0[i]) begin
            seen0[i] = 1'b0;
            seen1[i] = 1'b0;
        end
        run(28, -1, -1, 1'b0, 1'b1);
        miss0 = 0;
        miss1 = 0;
        foreach (seen0[i]) begin
            if (!seen0[i]) miss0++;
            if (!seen1[i]) miss1++;
        end
        chk("cover_s0", 0, 64'(miss0), 64'd0);
        chk("cover_s1", 0, 64'(miss1), 64'd0);

        // Start pulses while busy are ignored
        run(22, 5, 12, 1'b0, 1'b0);

        // Reset in cycle 12
        b1.start = 1'b1;
        step();
        b1.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            check1(c, c);
            if (c == 12) rst_n = 1'b0;
            step();
        end
        chk("mid_rst", 13, all1(), 64'h0);
        rst_n = 1'b1;
        for (int c = 14; c <= 24; c++) begin
            step();
            chk("post_rst", c, all1(), 64'h0);
        end
        run(20, -1, -1, 1'b0, 1'b0);

        // Start held high: back-to-back transforms, period 19
        run(39, -1, -1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/radix_8_ntt64_ctrl.md
Name: radix_8_ntt64_ctrl

Overview:
Sequencer for a 64-point, 2-stage radix-8 DIT NTT built around one shared radix_8_dit_ntt butterfly (N=17, Q=65537) and an 8-bank, conflict-free coefficient RAM. Per cycle it issues one butterfly's worth of bank row addresses, the crossbar rotation and the twiddle ROM address. It delays the same addresses for in-place write-back. Input coefficients are preloaded in digit-reversed order by the host; twiddle ROM contents and the crossbars are external.

Parameters:
RD_LAT, 1, read latency of coefficient banks and twiddle ROM in cycles; must be at least 1.
BF_LAT, 0, pipeline register stages inside the butterfly datapath; must be at least 0.
D (localparam), RD_LAT+BF_LAT, read-issue to write-back delay.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  begin a transform; sampled only while busy=0.
busy  out  1  transform in progress.
done  out  1  one-cycle pulse when the last write-back has completed.
rd_en  out  1  read issue for all 8 banks.
rd_row  out  24  row address for bank j at bits [3j+2:3j].
rd_rot  out  3  read crossbar rotation: lane k is fed from bank (k+rd_rot) mod 8.
tf_addr  out  4  twiddle ROM address {stage, b}; the ROM word holds tf1..tf7.
wr_en  out  1  write-back for all 8 banks.
wr_row  out  24  write row per bank, same packing as rd_row.
wr_rot  out  3  write crossbar rotation: lane k is written to bank (k+wr_rot) mod 8.

Behaviour:
- Coefficient i is stored in bank (i + i/8) mod 8, at row i/8 for stage-0 addressing.
- Stage 0, butterfly b (0..7): inputs are b+8k, k=0..7. Bank j row = (j-b) mod 8; rot = b.
- Stage 1, butterfly b: inputs are 8b+k. Every bank row = b; rot = b.
- tf_addr = {stage, b[2:0]}. It is issued in the same cycle as rd_en, so twiddles arrive aligned with the data.
- Outputs are registered and clocked from the FSM. When rd_en=0: rd_row, rd_rot and tf_addr are 0.
- Write path: a D-deep shift register carries {en, row, rot}. wr_* equal the rd_* values from D cycles earlier. When wr_en=0, wr_row and wr_rot are 0.
- FSM states: IDLE, STAGE0, DRAIN, STAGE1, FLUSH, DONE.
  - IDLE: start=1 -> STAGE0, with b=0.
  - STAGE0: b counts 0..7 with rd_en=1; after b=7 -> DRAIN.
  - DRAIN: D cycles with no reads, then -> STAGE1 with b=0. Stage 0's last write lands in the final DRAIN cycle, so the RAW hazard is avoided.
  - STAGE1: b counts 0..7; after b=7 -> FLUSH.
  - FLUSH: D cycles, then -> DONE.
  - DONE: done=1 and busy=0 for one cycle, then -> IDLE.
- Timing, with start sampled at edge t:
  - stage-0 reads in cycles t+1..t+8; stage-1 reads t+9+D..t+16+D;
  - last write in cycle t+16+2D; done in cycle t+17+2D;
  - busy=1 in cycles t+1..t+16+2D.
- start in the DONE cycle is accepted (busy=0). The next reads begin in the following cycle, so back-to-back transforms have period 17+2D.
- start while busy=1 is ignored; it has no effect on state or counters.
- Reset value of every output is 0, and the FSM returns to IDLE.
- Reset mid-operation clears the write shift register. No wr_en is asserted after the reset edge; the RAM contents are undefined for that transform.

Test Plan:
1. D=1, pulse start at edge 0 -> rd_en in cycles 1..8 and 10..17; wr_en in 2..9 and 11..18; done only in cycle 19; busy high in cycles 1..18.
2. Stage-0 b=3 -> rd_row banks 0..7 = 5,6,7,0,1,2,3,4 (rd_row=24'o43210765), rd_rot=3, tf_addr=3. Stage-1 b=3 -> all rows 3 (24'o33333333), rd_rot=3, tf_addr=11. wr_* show the same values one cycle later.
3. Pulse start again in cycles 5 and 12 of a running transform -> no change to the sequence; done still only in cycle 19.
4. Drive rst_n=0 in cycle 12 -> all outputs 0 from the next edge; no wr_en afterwards. After release, start -> a clean full sequence identical to scenario 1.
5. RD_LAT=2, BF_LAT=3 (D=5) -> stage-1 reads in cycles 14..21; last write in cycle 26; done in cycle 27.
6. D=1, start held high -> done in cycles 19 and 38; the second transform's first read is in cycle 20; rd_en is never high in cycle 19.
7. Exhaustive check of all 16 butterflies against the reference addressing formulas -> each bank is addressed exactly once per cycle, and the union of (bank, row) pairs over each stage covers all 64 locations.
